inc_dec_sched: RTL and testbench

INC_DEC_SCHED -- requirements
Module: inc_dec_sched

---
 rtl/inc_dec_sched.sv | 151 +++++++++++++++
 tb/tb_inc_dec_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/inc_dec_sched.sv
// Round-robin scheduler that turns four inc/dec requesters plus a clear command into single-cycle counter enables.
// Optional INC_DEC_SCHED_ERR_EN: ineligible requests are granted and acknowledged with ERR instead of being held.
module inc_dec_sched #(
  parameter int BITS_NUM = 8,
  parameter int MAX_VAL  = 2**BITS_NUM-1
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic [3:0]          REQ,
  input  logic [3:0]          DIR,
  input  logic                CLR_CMD,
  input  logic [BITS_NUM-1:0] Q,
  output logic                INC_CE,
  output logic                DEC_CE,
  output logic                CLR_OUT,
  output logic [3:0]          ACK,
  output logic                ERR,
  output logic                BUSY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  localparam logic [1:0] OP_INC = 2'd0;
  localparam logic [1:0] OP_DEC = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;
  localparam logic [1:0] OP_REJ = 2'd3;

  localparam logic [BITS_NUM-1:0] MAX_Q  = BITS_NUM'(MAX_VAL);
  localparam logic [BITS_NUM-1:0] ZERO_Q = {BITS_NUM{1'b0}};

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] op_q, op_d;
  logic       clr_pend_q, clr_pend_d;
  logic       inc_ce_q, inc_ce_d;
  logic       dec_ce_q, dec_ce_d;
  logic       clr_out_q, clr_out_d;
  logic [3:0] ack_q, ack_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic [3:0] elig_s;
  logic [3:0] cand_s;
  logic       found_s;
  logic [1:0] pick_s;

  // Eligibility against the fed-back counter value, and the set of requests allowed to arbitrate
  always_comb begin
    elig_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      elig_s[i] = DIR[i] ? (Q < MAX_Q) : (Q != ZERO_Q);
    end
`ifdef INC_DEC_SCHED_ERR_EN
    cand_s = REQ;
`else
    cand_s = REQ & elig_s;
`endif
  end

  // Round-robin search starting one past the last granted requester
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      pick_s  = (!found_s && cand_s[ptr_q + 2'(k)]) ? (ptr_q + 2'(k)) : pick_s;
      found_s = found_s | cand_s[ptr_q + 2'(k)];
    end
  end

  // FSM next state, grant capture and clear-command latch
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    clr_pend_d = clr_pend_q | CLR_CMD;
    case (state_q)
      IDLE: begin
        if (clr_pend_q || CLR_CMD) begin
          state_d    = ISSUE;
          op_d       = OP_CLR;
          clr_pend_d = 1'b0;
        end else if (found_s) begin
          state_d = ISSUE;
          gnt_d   = pick_s;
          ptr_d   = pick_s;
          op_d    = !elig_s[pick_s] ? OP_REJ : (DIR[pick_s] ? OP_INC : OP_DEC);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output stage trails the FSM by one cycle; BUSY spans the FSM and that trailing stage
  always_comb begin
    inc_ce_d  = (state_q == ISSUE) && (op_q == OP_INC);
    dec_ce_d  = (state_q == ISSUE) && (op_q == OP_DEC);
    clr_out_d = (state_q == ISSUE) && (op_q == OP_CLR);
    ack_d     = ((state_q == ISSUE) && (op_q != OP_CLR)) ? (4'b0001 << gnt_q) : 4'b0000;
`ifdef INC_DEC_SCHED_ERR_EN
    err_d     = (state_q == ISSUE) && (op_q == OP_REJ);
`else
    err_d     = 1'b0;
`endif
    busy_d    = (state_q != IDLE) || (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      gnt_q      <= 2'd0;
      op_q       <= OP_INC;
      clr_pend_q <= 1'b0;
      inc_ce_q   <= 1'b0;
      dec_ce_q   <= 1'b0;
      clr_out_q  <= 1'b0;
      ack_q      <= 4'b0000;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      clr_pend_q <= clr_pend_d;
      inc_ce_q   <= inc_ce_d;
      dec_ce_q   <= dec_ce_d;
      clr_out_q  <= clr_out_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign INC_CE  = inc_ce_q;
  assign DEC_CE  = dec_ce_q;
  assign CLR_OUT = clr_out_q;
  assign ACK     = ack_q;
  assign ERR     = err_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_inc_dec_sched.sv
// Directed self-checking bench for inc_dec_sched; outputs packed as {INC_CE,DEC_CE,CLR_OUT,ACK,ERR,BUSY}.
module tb_inc_dec_sched;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] DIR = 4'b0000;
  logic       CLR_CMD = 1'b0;
  logic [7:0] Q = 8'd0;
  logic       INC_CE, DEC_CE, CLR_OUT, ERR, BUSY;
  logic [3:0] ACK;
  logic [8:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  inc_dec_sched dut (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(REQ), .DIR(DIR), .CLR_CMD(CLR_CMD), .Q(Q),
    .INC_CE(INC_CE), .DEC_CE(DEC_CE), .CLR_OUT(CLR_OUT), .ACK(ACK), .ERR(ERR), .BUSY(BUSY)
  );

  assign obs = {INC_CE, DEC_CE, CLR_OUT, ACK, ERR, BUSY};

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    CLR_N = 1'b0; REQ = 4'b0000; CLR_CMD = 1'b0;
    tick();
    CLR_N = 1'b1;
  endtask

  task automatic test_reset;
    CLR_N = 1'b0; REQ = 4'b1111; DIR = 4'b1111; Q = 8'd5; CLR_CMD = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_checks++;
      if (obs !== 9'b000000000) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b expected %b", c, obs, 9'b000000000);
      end
    end
    do_reset();
  endtask

  task automatic test_single_inc;
    logic [8:0] exp_v;
    do_reset();
    Q = 8'd5; DIR = 4'b1111; REQ = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_v = (c == 2) ? 9'b100000101 : ((c == 1 || c == 3) ? 9'b000000001 : 9'b000000000);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_inc cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      if (c == 2) REQ = 4'b0000;
    end
  endtask

  task automatic test_round_robin;
    logic [8:0] exp_v;
    logic [3:0] ack_e;
    do_reset();
    Q = 8'd5; DIR = 4'b1111; REQ = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      tick();
      ack_e = 4'b0001 << ((c / 3) % 4);
      exp_v = (c % 3 == 2) ? {1'b1, 2'b00, ack_e, 1'b0, 1'b1} : 9'b000000001;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL round_robin cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
    REQ = 4'b0000;
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_dec_at_zero;
    logic [8:0] exp_v;
    do_reset();
    Q = 8'd0; DIR = 4'b0000; REQ = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      tick();
`ifdef INC_DEC_SCHED_ERR_EN
      exp_v = (c == 2) ? 9'b000010011 : ((c == 1 || c == 3) ? 9'b000000001 : 9'b000000000);
      if (c == 2) REQ = 4'b0000;
`else
      exp_v = 9'b000000000;
`endif
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL dec_at_zero cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
    REQ = 4'b0000;
  endtask

  task automatic test_max_bound;
    logic [8:0] exp_v;
    do_reset();
    Q = 8'd255; DIR = 4'b0010; REQ = 4'b1010;
    for (int c = 1; c <= 10; c++) begin
      tick();
`ifdef INC_DEC_SCHED_ERR_EN
      case (c)
        2:       exp_v = 9'b000001011;
        5:       exp_v = 9'b010100001;
        1, 3, 4, 6: exp_v = 9'b000000001;
        default: exp_v = 9'b000000000;
      endcase
      if (c == 2) REQ = 4'b1000;
      if (c == 5) REQ = 4'b0000;
`else
      case (c)
        2:       exp_v = 9'b010100001;
        1, 3:    exp_v = 9'b000000001;
        default: exp_v = 9'b000000000;
      endcase
      if (c == 2) REQ = 4'b0010;
`endif
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL max_bound cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
    REQ = 4'b0000;
  endtask

  task automatic test_clear_priority;
    logic [8:0] exp_v;
    do_reset();
    Q = 8'd5; DIR = 4'b1111; REQ = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      case (c)
        2:       exp_v = 9'b100001001;
        5:       exp_v = 9'b001000001;
        8:       exp_v = 9'b100000101;
        10:      exp_v = 9'b000000000;
        default: exp_v = 9'b000000001;
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL clear_priority cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      if (c == 2) begin
        REQ = 4'b0001;
        CLR_CMD = 1'b1;
      end
      if (c == 3) CLR_CMD = 1'b0;
      if (c == 8) REQ = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_issue;
    logic [8:0] exp_v;
    do_reset();
    Q = 8'd5; DIR = 4'b1111; REQ = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_v = (c == 2) ? 9'b100000101 : ((c == 1 || c == 3) ? 9'b000000001 : 9'b000000000);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL prime_ptr cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      if (c == 2) REQ = 4'b0000;
    end
    // requester 1 would win next; reset cut its op while in ISSUE
    REQ = 4'b0011;
    for (int c = 1; c <= 4; c++) begin
      tick();
      case (c)
        2:       exp_v = 9'b000000000;
        4:       exp_v = 9'b100000101;
        default: exp_v = 9'b000000001;
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_issue cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      CLR_N = (c == 1) ? 1'b0 : 1'b1;
    end
    REQ = 4'b0000;
    for (int c = 0; c < 3; c++) tick();
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_round_robin();
    test_dec_at_zero();
    test_max_bound();
    test_clear_priority();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
